mem_wb_stage: RTL and testbench

- Memory-to-writeback pipeline stage. It sits directly upstream of the 32x32 register file and drives its WriteEnable/DAddress/DData write port.
- Accepts one retiring instruction per handshake: either an ALU result or a load.
- For loads, waits for the data-memory response, extracts and sign/zero-extends the byte, half or word, then issues a single registered write.
- Exposes pending-load status to the hazard unit.

---
 rtl/mem_wb_if.sv | 42 ++++
 rtl/mem_wb_stage.sv | 131 +++++++++++++
 tb/tb_mem_wb_stage.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_if.sv
// Bundle between the memory stage, the data-memory response path and the
// register-file write port, as seen by the memory-to-writeback stage.
interface mem_wb_if #(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 5
) ();
  // Handshake: an instruction moves into the stage on a rising edge where
  // in_valid && in_ready; in_valid/fields must hold until then, in_ready never
  // depends on in_valid, and mem_rdata_valid is a one-cycle strobe with no ready.
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_reg_write;
  logic [ADDR_BITS-1:0] in_dest;
  logic                 in_mem_to_reg;
  logic [DATA_BITS-1:0] in_alu_result;
  logic [2:0]           in_load_type;
  logic [1:0]           in_byte_off;
  logic                 mem_rdata_valid;
  logic [DATA_BITS-1:0] mem_rdata;
  logic                 WriteEnable;
  logic [ADDR_BITS-1:0] DAddress;
  logic [DATA_BITS-1:0] DData;
  logic                 load_pending;
  logic [ADDR_BITS-1:0] pending_dest;
  logic                 misalign_err;
  logic                 timeout_err;

  modport master (
    output flush, in_valid, in_reg_write, in_dest, in_mem_to_reg,
           in_alu_result, in_load_type, in_byte_off, mem_rdata_valid, mem_rdata,
    input  in_ready, WriteEnable, DAddress, DData, load_pending, pending_dest,
           misalign_err, timeout_err
  );

  modport slave (
    input  flush, in_valid, in_reg_write, in_dest, in_mem_to_reg,
           in_alu_result, in_load_type, in_byte_off, mem_rdata_valid, mem_rdata,
    output in_ready, WriteEnable, DAddress, DData, load_pending, pending_dest,
           misalign_err, timeout_err
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-to-writeback stage: retires ALU results directly, waits for and
// extends load data, and issues one registered register-file write per op.
module mem_wb_stage #(
  parameter int DATA_BITS      = 32,
  parameter int ADDR_BITS      = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  mem_wb_if.slave    bus,
  output logic [1:0] dbg_state
);

  localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_BITS-1:0]  wait_cnt;
  logic [ADDR_BITS-1:0] ld_dest;
  logic [2:0]           ld_type;
  logic [1:0]           ld_off;
  logic                 ld_reg_write;
  logic                 accept;

  function automatic logic is_misaligned(input logic [2:0] t, input logic [1:0] off);
    case (t)
      3'd1, 3'd2: is_misaligned = 1'b0;
      3'd3, 3'd4: is_misaligned = off[0];
      default:    is_misaligned = (off != 2'd0);
    endcase
  endfunction

  function automatic logic [DATA_BITS-1:0] extract(input logic [2:0] t,
                                                   input logic [1:0] off,
                                                   input logic [DATA_BITS-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (t)
      3'd1:    extract = {{(DATA_BITS-8){b[7]}}, b};
      3'd2:    extract = {{(DATA_BITS-8){1'b0}}, b};
      3'd3:    extract = {{(DATA_BITS-16){h[15]}}, h};
      3'd4:    extract = {{(DATA_BITS-16){1'b0}}, h};
      default: extract = word;
    endcase
  endfunction

  assign bus.in_ready     = (state == IDLE) && !bus.flush;
  assign accept           = bus.in_valid && bus.in_ready;
  assign bus.load_pending = (state == WAIT_MEM);
  assign bus.pending_dest = (state == WAIT_MEM) ? ld_dest : '0;
  assign dbg_state        = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      wait_cnt         <= '0;
      ld_dest          <= '0;
      ld_type          <= '0;
      ld_off           <= '0;
      ld_reg_write     <= 1'b0;
      bus.WriteEnable  <= 1'b0;
      bus.DAddress     <= '0;
      bus.DData        <= '0;
      bus.misalign_err <= 1'b0;
      bus.timeout_err  <= 1'b0;
    end else begin
      bus.WriteEnable  <= 1'b0;
      bus.misalign_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!bus.in_mem_to_reg) begin
              if (bus.in_reg_write && (bus.in_dest != '0)) begin
                bus.WriteEnable <= 1'b1;
                bus.DAddress    <= bus.in_dest;
                bus.DData       <= bus.in_alu_result;
              end
            end else if (is_misaligned(bus.in_load_type, bus.in_byte_off)) begin
              bus.misalign_err <= 1'b1;
            end else begin
              ld_dest      <= bus.in_dest;
              ld_type      <= bus.in_load_type;
              ld_off       <= bus.in_byte_off;
              ld_reg_write <= bus.in_reg_write;
              wait_cnt     <= '0;
              state        <= WAIT_MEM;
            end
          end
        end
        WAIT_MEM: begin
          // A response always beats both flush and timeout in the same cycle.
          if (bus.mem_rdata_valid) begin
            if (!bus.flush && ld_reg_write && (ld_dest != '0)) begin
              bus.WriteEnable <= 1'b1;
              bus.DAddress    <= ld_dest;
              bus.DData       <= extract(ld_type, ld_off, bus.mem_rdata);
            end
            state <= IDLE;
          end else if (wait_cnt == CNT_LAST) begin
            bus.timeout_err <= 1'b1;
            state           <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_BITS'(1);
            if (bus.flush) state <= DRAIN;
          end
        end
        DRAIN: begin
          // The squashed load's response is still owed; swallow it.
          if (bus.mem_rdata_valid) begin
            state <= IDLE;
          end else if (wait_cnt == CNT_LAST) begin
            bus.timeout_err <= 1'b1;
            state           <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_BITS'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed and randomized ALU/load
// traffic, flush, timeout and reset cases against a behavioural model.
module tb_mem_wb_stage;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         checks;
  int         errors;
  logic [36:0] exp_q[$];

  mem_wb_if #(.DATA_BITS(32), .ADDR_BITS(5)) bus ();

  mem_wb_stage #(.DATA_BITS(32), .ADDR_BITS(5), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: every register-file write must match the head of exp_q
  always @(negedge clk) begin
    if (bus.WriteEnable === 1'b1) begin
      logic [36:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%0d data=%h, required no write",
                 bus.DAddress, bus.DData);
      end else begin
        e = exp_q.pop_front();
        if ({bus.DAddress, bus.DData} !== e) begin
          errors++;
          $display("FAIL write_value got addr=%0d data=%h, required addr=%0d data=%h",
                   bus.DAddress, bus.DData, e[36:32], e[31:0]);
        end
      end
    end
  end

  // reference: load extraction from the raw word using shifts
  function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] s;
    case (t)
      3'd1: begin s = w >> (8 * off); return {{24{s[7]}}, s[7:0]}; end
      3'd2: begin s = w >> (8 * off); return {24'h0, s[7:0]}; end
      3'd3: begin s = w >> (off[1] ? 16 : 0); return {{16{s[15]}}, s[15:0]}; end
      3'd4: begin s = w >> (off[1] ? 16 : 0); return {16'h0, s[15:0]}; end
      default: return w;
    endcase
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush           = 1'b0;
    bus.in_valid        = 1'b0;
    bus.in_reg_write    = 1'b0;
    bus.in_dest         = '0;
    bus.in_mem_to_reg   = 1'b0;
    bus.in_alu_result   = '0;
    bus.in_load_type    = '0;
    bus.in_byte_off     = '0;
    bus.mem_rdata_valid = 1'b0;
    bus.mem_rdata       = '0;
  endtask

  task automatic drive_op(input logic mtr, input logic [2:0] t, input logic [1:0] off,
                          input logic [4:0] dest, input logic rw, input logic [31:0] alu);
    bus.in_valid      = 1'b1;
    bus.in_mem_to_reg = mtr;
    bus.in_load_type  = t;
    bus.in_byte_off   = off;
    bus.in_dest       = dest;
    bus.in_reg_write  = rw;
    bus.in_alu_result = alu;
  endtask

  // Load with response in waiting cycle lat (1 = first cycle after accept).
  task automatic run_load(input logic [2:0] t, input logic [1:0] off, input logic [4:0] dest,
                          input logic rw, input logic [31:0] word, input logic [31:0] exp_data,
                          input int lat);
    drive_op(1'b1, t, off, dest, rw, $urandom);
    bus.mem_rdata_valid = 1'($urandom_range(0, 1));
    bus.mem_rdata       = $urandom;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_accept_ready got %b, required 1", bus.in_ready);
    end
    tick();
    idle_inputs();
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.load_pending !== 1'b1 || bus.pending_dest !== dest) begin
        errors++;
        $display("FAIL load_wait got ready=%b pending=%b pdest=%0d, required 0 1 %0d",
                 bus.in_ready, bus.load_pending, bus.pending_dest, dest);
      end
      tick();
    end
    bus.mem_rdata_valid = 1'b1;
    bus.mem_rdata       = word;
    if (rw && dest != 0) exp_q.push_back({dest, exp_data});
    tick();
    bus.mem_rdata_valid = 1'b0;
    bus.mem_rdata       = $urandom;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.load_pending !== 1'b0 ||
        bus.WriteEnable !== ((rw && dest != 0) ? 1'b1 : 1'b0)) begin
      errors++;
      $display("FAIL load_done got ready=%b pending=%b we=%b, required 1 0 %b",
               bus.in_ready, bus.load_pending, bus.WriteEnable, rw && dest != 0);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.WriteEnable !== 1'b0 || bus.DAddress !== 5'd0 || bus.DData !== 32'd0 ||
        bus.misalign_err !== 1'b0 || bus.timeout_err !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.load_pending !== 1'b0 || bus.pending_dest !== 5'd0) begin
      errors++;
      $display("FAIL reset_state got we=%b addr=%0d data=%h mis=%b to=%b rdy=%b lp=%b pd=%0d, required 0 0 0 0 0 1 0 0",
               bus.WriteEnable, bus.DAddress, bus.DData, bus.misalign_err, bus.timeout_err,
               bus.in_ready, bus.load_pending, bus.pending_dest);
    end
    tick();
  endtask

  task automatic test_alu();
    drive_op(1'b0, 3'd0, 2'd0, 5'd5, 1'b1, 32'hDEADBEEF);
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus.WriteEnable !== 1'b1 || bus.DAddress !== 5'd5 || bus.DData !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL alu_write got we=%b addr=%0d data=%h, required 1 5 deadbeef",
               bus.WriteEnable, bus.DAddress, bus.DData);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.WriteEnable !== 1'b0) begin
      errors++;
      $display("FAIL alu_pulse got we=%b, required 0", bus.WriteEnable);
    end
    // r0 writes and non-writing ops never reach the register file
    drive_op(1'b0, 3'd0, 2'd0, 5'd0, 1'b1, 32'h12345678);
    tick();
    drive_op(1'b0, 3'd0, 2'd0, 5'd9, 1'b0, 32'h12345678);
    tick();
    for (int i = 0; i < 24; i++) begin
      logic [4:0]  d;
      logic        rw;
      logic [31:0] v;
      d  = 5'($urandom_range(0, 31));
      rw = ($urandom_range(0, 3) != 0);
      v  = $urandom;
      drive_op(1'b0, 3'($urandom), 2'($urandom), d, rw, v);
      if (rw && d != 0) exp_q.push_back({d, v});
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL alu_b2b_ready got %b, required 1", bus.in_ready);
      end
      tick();
    end
    idle_inputs();
    tick();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL alu_b2b_drained got %0d writes outstanding, required 0", exp_q.size());
    end
    tick();
  endtask

  task automatic test_loads();
    logic [31:0] w;
    w = 32'h80FF7F01;
    run_load(3'd1, 2'd3, 5'd1, 1'b1, w, 32'hFFFFFF80, 3);
    run_load(3'd2, 2'd1, 5'd2, 1'b1, w, 32'h0000007F, 3);
    run_load(3'd3, 2'd2, 5'd3, 1'b1, w, 32'hFFFF80FF, 3);
    run_load(3'd4, 2'd0, 5'd4, 1'b1, w, 32'h00007F01, 3);
    run_load(3'd0, 2'd0, 5'd6, 1'b1, w, 32'h80FF7F01, 3);
    run_load(3'd0, 2'd0, 5'd0, 1'b1, w, 32'h80FF7F01, 3);
    for (int i = 0; i < 30; i++) begin
      logic [2:0]  t;
      logic [1:0]  off;
      logic [4:0]  d;
      logic        rw;
      logic [31:0] rw_word;
      t = 3'($urandom_range(0, 7));
      case (t)
        3'd1, 3'd2: off = 2'($urandom_range(0, 3));
        3'd3, 3'd4: off = {1'($urandom_range(0, 1)), 1'b0};
        default:    off = 2'd0;
      endcase
      d       = 5'($urandom_range(0, 31));
      rw      = ($urandom_range(0, 3) != 0);
      rw_word = $urandom;
      run_load(t, off, d, rw, rw_word, ref_load(t, off, rw_word), $urandom_range(1, 4));
    end
  endtask

  task automatic test_misalign();
    logic [2:0] tt [3];
    logic [1:0] oo [3];
    tt = '{3'd3, 3'd0, 3'd4};
    oo = '{2'd1, 2'd2, 2'd3};
    for (int i = 0; i < 3; i++) begin
      drive_op(1'b1, tt[i], oo[i], 5'd9, 1'b1, 32'h0);
      tick();
      idle_inputs();
      @(negedge clk);
      checks++;
      if (bus.misalign_err !== 1'b1 || bus.in_ready !== 1'b1 || bus.load_pending !== 1'b0 ||
          bus.WriteEnable !== 1'b0) begin
        errors++;
        $display("FAIL misalign_pulse type=%0d off=%0d got mis=%b rdy=%b lp=%b we=%b, required 1 1 0 0",
                 tt[i], oo[i], bus.misalign_err, bus.in_ready, bus.load_pending, bus.WriteEnable);
      end
      tick();
      @(negedge clk);
      checks++;
      if (bus.misalign_err !== 1'b0) begin
        errors++;
        $display("FAIL misalign_one_cycle got %b, required 0", bus.misalign_err);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    // flush while idle blocks acceptance
    drive_op(1'b0, 3'd0, 2'd0, 5'd3, 1'b1, 32'hCAFE0003);
    bus.flush = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_ready got %b, required 0", bus.in_ready);
    end
    tick();
    idle_inputs();
    tick();
    // flush while waiting, then the owed response arrives
    drive_op(1'b1, 3'd0, 2'd0, 5'd7, 1'b1, 32'h0);
    tick();
    idle_inputs();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive_op(1'b0, 3'd0, 2'd0, 5'd8, 1'b1, 32'hCAFE0008);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.load_pending !== 1'b0 || bus.pending_dest !== 5'd0) begin
      errors++;
      $display("FAIL drain_status got rdy=%b lp=%b pd=%0d, required 0 0 0",
               bus.in_ready, bus.load_pending, bus.pending_dest);
    end
    tick();
    bus.mem_rdata_valid = 1'b1;
    bus.mem_rdata       = 32'h11111111;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL drain_resp_ready got %b, required 0", bus.in_ready);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.WriteEnable !== 1'b0) begin
      errors++;
      $display("FAIL drain_exit got rdy=%b we=%b, required 1 0", bus.in_ready, bus.WriteEnable);
    end
    tick();
    // flush coincident with the response discards it
    drive_op(1'b1, 3'd0, 2'd0, 5'd10, 1'b1, 32'h0);
    tick();
    idle_inputs();
    bus.flush           = 1'b1;
    bus.mem_rdata_valid = 1'b1;
    bus.mem_rdata       = 32'h22222222;
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.load_pending !== 1'b0 || bus.WriteEnable !== 1'b0) begin
      errors++;
      $display("FAIL flush_with_resp got rdy=%b lp=%b we=%b, required 1 0 0",
               bus.in_ready, bus.load_pending, bus.WriteEnable);
    end
    tick();
  endtask

  task automatic test_timeout();
    drive_op(1'b1, 3'd0, 2'd0, 5'd11, 1'b1, 32'h0);
    tick();
    idle_inputs();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.timeout_err !== 1'b0 || bus.load_pending !== 1'b1) begin
        errors++;
        $display("FAIL timeout_wait cycle=%0d got to=%b lp=%b, required 0 1",
                 i, bus.timeout_err, bus.load_pending);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (bus.timeout_err !== 1'b1 || bus.in_ready !== 1'b1 || bus.load_pending !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire got to=%b rdy=%b lp=%b, required 1 1 0",
               bus.timeout_err, bus.in_ready, bus.load_pending);
    end
    tick();
    bus.mem_rdata_valid = 1'b1;
    bus.mem_rdata       = 32'h33333333;
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.timeout_err !== 1'b1 || bus.WriteEnable !== 1'b0) begin
        errors++;
        $display("FAIL timeout_sticky got to=%b we=%b, required 1 0",
                 bus.timeout_err, bus.WriteEnable);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    v = $urandom | 32'h1;
    drive_op(1'b0, 3'd0, 2'd0, 5'd12, 1'b1, v);
    exp_q.push_back({5'd12, v});
    tick();
    drive_op(1'b1, 3'd0, 2'd0, 5'd13, 1'b1, 32'h0);
    tick();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.load_pending !== 1'b1 || bus.pending_dest !== 5'd13) begin
      errors++;
      $display("FAIL rst_mid_pre got lp=%b pd=%0d, required 1 13", bus.load_pending, bus.pending_dest);
    end
    tick();
    rst                 = 1'b0;
    bus.mem_rdata_valid = 1'b1;
    bus.mem_rdata       = 32'h44444444;
    @(negedge clk);
    checks++;
    if (bus.WriteEnable !== 1'b0 || bus.DAddress !== 5'd0 || bus.DData !== 32'd0 ||
        bus.misalign_err !== 1'b0 || bus.timeout_err !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.load_pending !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_state got we=%b addr=%0d data=%h mis=%b to=%b rdy=%b lp=%b, required 0 0 0 0 0 1 0",
               bus.WriteEnable, bus.DAddress, bus.DData, bus.misalign_err, bus.timeout_err,
               bus.in_ready, bus.load_pending);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus.WriteEnable !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_no_write got we=%b, required 0", bus.WriteEnable);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_alu();
    test_loads();
    test_misalign();
    test_flush();
    test_timeout();
    test_reset_mid();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_drain got %0d writes outstanding, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
